inst_fetch: RTL

- Instruction fetch stage; sits directly upstream of the i-cache and downstream-feeds the decoder.
- Holds the PC and issues one 32-bit fetch per cycle to the i-cache.
- Tracks i-cache miss/refill, buffers fetched instructions with their PCs in a circular instruction queue, and applies branch/exception redirects.
- Redirects are deferred while a refill is outstanding, so the cache always fills the address it missed on.

---
 rtl/inst_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, i-cache miss tracking, branch and
// exception redirects, and a circular instruction queue for decode.
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int QUEUE_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  if_icache_en_out,
  output logic [ADDR_WIDTH-1:0] if_icache_inst_addr_out,
  input  logic                  icache_if_rdy_in,
  input  logic                  icache_if_miss_in,
  input  logic [INST_WIDTH-1:0] icache_if_inst_inst_in,
  input  logic                  redirect_en_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  input  logic                  dec_ready_in,
  output logic                  iq_valid_out,
  output logic [INST_WIDTH-1:0] iq_inst_out,
  output logic [ADDR_WIDTH-1:0] iq_pc_out
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } iq_entry_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic                  pend;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW:0]           count;
  iq_entry_t             mem [QUEUE_DEPTH];
  iq_entry_t             head_e;

  logic full;
  logic hit;
  logic miss;
  logic pop;
  logic redir_now;
  logic redir_late;

  assign full = (count == DEPTH);
  assign iq_valid_out = (count != '0);

  assign if_icache_en_out = rdy_in & ~rst_in & ~full
                          & ~pend & ~redirect_en_in;
  assign if_icache_inst_addr_out = pc;

  assign hit  = if_icache_en_out & icache_if_rdy_in & ~icache_if_miss_in;
  assign miss = if_icache_en_out & icache_if_rdy_in & icache_if_miss_in;
  assign pop  = iq_valid_out & dec_ready_in & rdy_in & ~redirect_en_in;

  // A redirect may only move the pc while no refill is in flight.
  assign redir_now = redirect_en_in & rdy_in & icache_if_rdy_in
                   & (state == S_FETCH);
  assign redir_late = ~redirect_en_in & pend & rdy_in & icache_if_rdy_in;

  assign head_e = mem[head];
  assign iq_inst_out = iq_valid_out ? head_e.inst : '0;
  assign iq_pc_out = iq_valid_out ? head_e.pc : '0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (redirect_en_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      if (redir_now) begin
        pc    <= redirect_pc_in;
        pend  <= 1'b0;
        state <= S_FETCH;
      end else begin
        pend    <= 1'b1;
        pend_pc <= redirect_pc_in;
      end
    end else if (rdy_in) begin
      if (redir_late) begin
        pc    <= pend_pc;
        pend  <= 1'b0;
        state <= S_FETCH;
      end else if (hit) begin
        pc    <= pc + ADDR_WIDTH'(4);
        state <= S_FETCH;
      end else if (miss) begin
        state <= S_WAIT;
      end
      if (hit)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      if (hit && !pop)
        count <= count + (PW+1)'(1);
      else if (pop && !hit)
        count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (hit)
      mem[tail] <= '{pc: pc, inst: icache_if_inst_inst_in};
  end

endmodule
